// File: rtl/level_monitor_core.sv
// Level-measurement core: sensor glitch filter, threshold store, alarm FSM and level PWM.
// Define LEVEL_HYST_EN to add a one-step hysteresis band on the HIGH/LOW exits.
`timescale 1ns/1ps
module level_monitor_core #(
  parameter int N_SENSORS     = 8,
  parameter int LEVEL_W       = $clog2(N_SENSORS + 1),
  parameter int STABLE_CYCLES = 16,
  parameter int PWM_W         = 8
) (
  input  logic                 clk_100MHz,
  input  logic                 reset_button_n,
  input  logic [N_SENSORS-1:0] sensors_input,
  input  logic [N_SENSORS-1:0] setup_input,
  input  logic                 saveH_button,
  input  logic                 saveL_button,
  output logic [LEVEL_W-1:0]   level,
  output logic [LEVEL_W-1:0]   thr_high,
  output logic [LEVEL_W-1:0]   thr_low,
  output logic [1:0]           state,
  output logic                 alarm_high,
  output logic                 alarm_low,
  output logic                 fault,
  output logic                 led_pwm
);

  localparam logic [1:0] ST_NORMAL = 2'b00;
  localparam logic [1:0] ST_HIGH   = 2'b01;
  localparam logic [1:0] ST_LOW    = 2'b10;
  localparam logic [1:0] ST_FAULT  = 2'b11;

  localparam int                   CNT_W      = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_MAX    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_ACC    = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [LEVEL_W-1:0]   LEVEL_FULL = LEVEL_W'(N_SENSORS);
  localparam logic [N_SENSORS-1:0] ONE_N      = N_SENSORS'(1);
  localparam int                   DUTY_W     = PWM_W + LEVEL_W;

  function automatic logic is_thermo(input logic [N_SENSORS-1:0] p);
    return (p & (p + ONE_N)) == '0;
  endfunction

  function automatic logic [LEVEL_W-1:0] popcount(input logic [N_SENSORS-1:0] p);
    logic [LEVEL_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_SENSORS; i++) c = c + LEVEL_W'(p[i]);
    return c;
  endfunction

  logic [N_SENSORS-1:0] sens_s1, sens_s2, setup_s1, setup_s2;
  logic [1:0]           btn_s1, btn_s2, btn_prev, btn_rise;

  always_ff @(posedge clk_100MHz or negedge reset_button_n) begin
    if (!reset_button_n) begin
      sens_s1  <= '0;
      sens_s2  <= '0;
      setup_s1 <= '0;
      setup_s2 <= '0;
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '0;
    end else begin
      sens_s1  <= sensors_input;
      sens_s2  <= sens_s1;
      setup_s1 <= setup_input;
      setup_s2 <= setup_s1;
      btn_s1   <= {saveH_button, saveL_button};
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  // bit 1 = saveH, bit 0 = saveL
  assign btn_rise = btn_s2 & ~btn_prev;

  logic [N_SENSORS-1:0] cand;
  logic [CNT_W-1:0]     stab_cnt;
  logic                 fault_cond;

  // The candidate is accepted on the sample that brings the run length to STABLE_CYCLES.
  always_ff @(posedge clk_100MHz or negedge reset_button_n) begin
    if (!reset_button_n) begin
      cand       <= '0;
      stab_cnt   <= '0;
      level      <= '0;
      fault_cond <= 1'b0;
    end else if (sens_s2 != cand) begin
      cand     <= sens_s2;
      stab_cnt <= '0;
    end else begin
      if (stab_cnt != CNT_MAX) stab_cnt <= stab_cnt + CNT_W'(1);
      if (stab_cnt >= CNT_ACC) begin
        if (is_thermo(cand)) begin
          level      <= popcount(cand);
          fault_cond <= 1'b0;
        end else begin
          fault_cond <= 1'b1;
        end
      end
    end
  end

  logic               setup_ok;
  logic [LEVEL_W-1:0] setup_val;

  assign setup_ok  = is_thermo(setup_s2);
  assign setup_val = popcount(setup_s2);

  // Simultaneous edges decode the same setup pattern, so the new pair is never
  // strictly ordered and neither threshold is written.
  always_ff @(posedge clk_100MHz or negedge reset_button_n) begin
    if (!reset_button_n) begin
      thr_high <= LEVEL_FULL;
      thr_low  <= '0;
    end else if (btn_rise == 2'b10) begin
      if (setup_ok && (setup_val > thr_low)) thr_high <= setup_val;
    end else if (btn_rise == 2'b01) begin
      if (setup_ok && (setup_val < thr_high)) thr_low <= setup_val;
    end
  end

  logic [LEVEL_W-1:0] high_exit, low_exit;

`ifdef LEVEL_HYST_EN
  assign high_exit = (thr_high == '0) ? '0 : thr_high - LEVEL_W'(1);
  assign low_exit  = (thr_low >= LEVEL_FULL) ? LEVEL_FULL : thr_low + LEVEL_W'(1);
`else
  assign high_exit = thr_high;
  assign low_exit  = thr_low;
`endif

  logic [1:0] state_next;

  always_comb begin
    state_next = state;
    if (fault_cond) begin
      state_next = ST_FAULT;
    end else begin
      case (state)
        ST_FAULT:  state_next = ST_NORMAL;
        ST_NORMAL: begin
          if (level >= thr_high)     state_next = ST_HIGH;
          else if (level <= thr_low) state_next = ST_LOW;
        end
        ST_HIGH:   if (level < high_exit) state_next = ST_NORMAL;
        ST_LOW:    if (level > low_exit)  state_next = ST_NORMAL;
        default:   state_next = ST_NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_button_n) begin
    if (!reset_button_n) state <= ST_NORMAL;
    else                 state <= state_next;
  end

  assign alarm_high = (state == ST_HIGH);
  assign alarm_low  = (state == ST_LOW);
  assign fault      = (state == ST_FAULT);

  logic [PWM_W-1:0]  pwm_cnt;
  logic [DUTY_W-1:0] duty_lhs, duty_rhs;

  // Full-width compare: cnt*N < level*2^PWM_W gives exact level/N duty.
  assign duty_lhs = DUTY_W'(pwm_cnt) * DUTY_W'(N_SENSORS);
  assign duty_rhs = {level, {PWM_W{1'b0}}};

  always_ff @(posedge clk_100MHz or negedge reset_button_n) begin
    if (!reset_button_n) begin
      pwm_cnt <= '0;
      led_pwm <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      led_pwm <= (duty_lhs < duty_rhs);
    end
  end

endmodule

// File: tb/tb_level_monitor_core.sv
// Self-checking bench for level_monitor_core: vector tables, hand-written corner
// sequences and randomized stimulus against a rule-level reference model.
`timescale 1ns/1ps
module tb_level_monitor_core;
  localparam int N  = 8;
  localparam int LW = 4;
  localparam int S  = 16;
  localparam int PW = 8;
  localparam int ST_N = 0, ST_H = 1, ST_L = 2, ST_F = 3;
`ifdef LEVEL_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]  sensors, setup;
  logic          save_h, save_l;
  logic [LW-1:0] level, thr_high, thr_low;
  logic [1:0]    state;
  logic          alarm_high, alarm_low, fault, led_pwm;

  level_monitor_core #(.N_SENSORS(N), .LEVEL_W(LW), .STABLE_CYCLES(S), .PWM_W(PW)) dut (
    .clk_100MHz(clk), .reset_button_n(rst_n),
    .sensors_input(sensors), .setup_input(setup),
    .saveH_button(save_h), .saveL_button(save_l),
    .level(level), .thr_high(thr_high), .thr_low(thr_low), .state(state),
    .alarm_high(alarm_high), .alarm_low(alarm_low), .fault(fault), .led_pwm(led_pwm)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [LW-1:0] exp_q[$];

  int m_level, m_fault, m_thr_h, m_thr_l, m_state;
  logic [N-1:0] cur_sens;

  typedef struct { logic [N-1:0] sens; int exp_level; int exp_state; } vec_t;
  typedef struct { logic [N-1:0] sens; int exp_high; } pwm_vec_t;
  vec_t     vecs[7];
  pwm_vec_t pvecs[4];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // A pattern is a proper column reading iff it equals 2^k-1 with k wet bits.
  function automatic bit model_valid(input logic [N-1:0] p);
    int k = $countones(p);
    return int'(p) == ((1 << k) - 1);
  endfunction

  function automatic int next_state(input int s, input int lvl, input int th, input int tl, input int f);
    int lim;
    if (f != 0) return ST_F;
    if (s == ST_F) return ST_N;
    if (s == ST_N) begin
      if (lvl >= th) return ST_H;
      if (lvl <= tl) return ST_L;
      return ST_N;
    end
    if (s == ST_H) begin
      lim = HYST ? ((th > 0) ? th - 1 : 0) : th;
      return (lvl < lim) ? ST_N : ST_H;
    end
    lim = HYST ? ((tl + 1 > N) ? N : tl + 1) : tl;
    return (lvl > lim) ? ST_N : ST_L;
  endfunction

  task automatic settle_state();
    repeat (3) m_state = next_state(m_state, m_level, m_thr_h, m_thr_l, m_fault);
  endtask

  task automatic model_reset();
    m_level = 0; m_fault = 0; m_thr_h = N; m_thr_l = 0; m_state = ST_N;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_level"}, int'(level), m_level);
    check({tag, "_thr_high"}, int'(thr_high), m_thr_h);
    check({tag, "_thr_low"}, int'(thr_low), m_thr_l);
    check({tag, "_state"}, int'(state), m_state);
    check({tag, "_alarm_high"}, int'(alarm_high), int'(m_state == ST_H));
    check({tag, "_alarm_low"}, int'(alarm_low), int'(m_state == ST_L));
    check({tag, "_fault"}, int'(fault), int'(m_state == ST_F));
  endtask

  // driver tasks
  task automatic apply_sensors(input logic [N-1:0] p);
    sensors = p;
    cur_sens = p;
    tick(S + 6);
    if (model_valid(p)) begin
      m_level = $countones(p);
      m_fault = 0;
    end else begin
      m_fault = 1;
    end
    settle_state();
  endtask

  task automatic press(input bit h, input bit l, input logic [N-1:0] pat);
    int v;
    setup = pat;
    tick(3);
    save_h = h;
    save_l = l;
    tick(6);
    save_h = 1'b0;
    save_l = 1'b0;
    tick(4);
    v = $countones(pat);
    if (h && !l) begin
      if (model_valid(pat) && v > m_thr_l) m_thr_h = v;
    end else if (l && !h) begin
      if (model_valid(pat) && v < m_thr_h) m_thr_l = v;
    end
    settle_state();
  endtask

  task automatic check_pwm(input string name, input int exp);
    int hi = 0;
    repeat (256) begin
      @(negedge clk);
      hi += int'(led_pwm);
    end
    check(name, hi, exp);
  endtask

  initial begin
    vecs[0] = '{8'b00010001, 3, ST_F};
    vecs[1] = '{8'b11111111, 8, ST_H};
    vecs[2] = '{8'b00000000, 0, ST_L};
    vecs[3] = '{8'b00001111, 4, ST_N};
    vecs[4] = '{8'b10000000, 4, ST_F};
    vecs[5] = '{8'b00111111, 6, ST_N};
    vecs[6] = '{8'b00000111, 3, ST_N};
    pvecs[0] = '{8'b00001111, 128};
    pvecs[1] = '{8'b11111111, 256};
    pvecs[2] = '{8'b00000000, 0};
    pvecs[3] = '{8'b00000111, 96};

    rst_n = 1'b1; sensors = '0; setup = '0; save_h = 1'b0; save_l = 1'b0;
    #2 rst_n = 1'b0;
    tick(4);
    check("rst_level", int'(level), 0);
    check("rst_thr_high", int'(thr_high), 8);
    check("rst_thr_low", int'(thr_low), 0);
    check("rst_state", int'(state), ST_N);
    check("rst_alarms", int'({alarm_high, alarm_low, fault}), 0);
    check("rst_led", int'(led_pwm), 0);
    rst_n = 1'b1;
    #1 check("rel_state", int'(state), ST_N);
    model_reset();
    cur_sens = '0;
    tick(S + 6);
    settle_state();
    check_outputs("post_reset");

    // exact acceptance latency, state one edge behind
    sensors = 8'b00000111;
    cur_sens = sensors;
    tick(S + 1);
    check("lat_before", int'(level), 0);
    tick(1);
    check("lat_at", int'(level), 3);
    check("lat_state_old", int'(state), ST_L);
    tick(1);
    check("lat_state_new", int'(state), ST_N);
    tick(S);
    m_level = 3;
    settle_state();

    // glitch rejection and the STABLE_CYCLES boundary
    sensors = 8'b00001111; tick(10); sensors = cur_sens; tick(S + 6);
    check("glitch_10", int'(level), 3);
    sensors = 8'b00001111; tick(S - 1); sensors = cur_sens; tick(S + 6);
    check("glitch_S_minus_1", int'(level), 3);
    sensors = 8'b00001111; tick(S); sensors = cur_sens; tick(2);
    check("glitch_S_accept", int'(level), 4);
    tick(S + 6);
    check("glitch_S_return", int'(level), 3);
    settle_state();

    for (int i = 0; i < 7; i++) begin
      apply_sensors(vecs[i].sens);
      check($sformatf("vec%0d_level", i), int'(level), vecs[i].exp_level);
      check($sformatf("vec%0d_state", i), int'(state), vecs[i].exp_state);
      check($sformatf("vec%0d_fault", i), int'(fault), int'(vecs[i].exp_state == ST_F));
      check($sformatf("vec%0d_ahigh", i), int'(alarm_high), int'(vecs[i].exp_state == ST_H));
    end

    for (int i = 0; i < 4; i++) begin
      apply_sensors(pvecs[i].sens);
      check_pwm($sformatf("pwm%0d", i), pvecs[i].exp_high);
    end

    // threshold save: 3-edge latency, state one edge later, hold saves once
    setup = 8'b00000111;
    tick(3);
    save_l = 1'b1;
    tick(2);
    check("save_lat_2", int'(thr_low), 0);
    tick(1);
    check("save_lat_3", int'(thr_low), 3);
    check("save_state_old", int'(state), ST_N);
    tick(1);
    check("save_state_new", int'(state), ST_L);
    setup = 8'b00000001;
    tick(8);
    check("save_hold_once", int'(thr_low), 3);
    save_l = 1'b0;
    tick(4);
    m_thr_l = 3;
    settle_state();

    press(1'b1, 1'b0, 8'b00000011);
    check("saveH_below_low", int'(thr_high), 8);
    press(1'b0, 1'b1, 8'b00101011);
    check("saveL_invalid", int'(thr_low), 3);
    press(1'b1, 1'b0, 8'b00111111);
    check("saveH_ok", int'(thr_high), 6);
    press(1'b1, 1'b1, 8'b00001111);
    check("save_both_high", int'(thr_high), 6);
    check("save_both_low", int'(thr_low), 3);
    press(1'b0, 1'b1, 8'b00000001);
    check_outputs("saveL_1");

    // hysteresis band around thr_high=6 and thr_low=1
    apply_sensors(8'b00111111);
    check("hyst_h6", int'(state), ST_H);
    apply_sensors(8'b00011111);
    check("hyst_h5", int'(state), HYST ? ST_H : ST_N);
    apply_sensors(8'b00001111);
    check("hyst_h4", int'(state), ST_N);
    apply_sensors(8'b00000001);
    check("hyst_l1", int'(state), ST_L);
    apply_sensors(8'b00000011);
    check("hyst_l2", int'(state), HYST ? ST_L : ST_N);
    apply_sensors(8'b00000111);
    check_outputs("hyst_l3");

    // asynchronous reset mid-operation
    apply_sensors(8'b11111111);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_level", int'(level), 0);
    check("midrst_thr_high", int'(thr_high), 8);
    check("midrst_thr_low", int'(thr_low), 0);
    check("midrst_state", int'(state), ST_N);
    check("midrst_led", int'(led_pwm), 0);
    tick(2);
    rst_n = 1'b1;
    model_reset();
    settle_state();
    tick(S + 6);
    m_level = 8;
    settle_state();
    check_outputs("midrst_after");

    // randomized phase
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] p;
      if ($urandom_range(0, 3) == 0) begin
        sensors = N'($urandom);
        tick($urandom_range(1, S - 1));
        sensors = cur_sens;
        tick(2);
      end
      if ($urandom_range(0, 2) != 0) p = N'((1 << $urandom_range(0, N)) - 1);
      else                           p = N'($urandom);
      apply_sensors(p);
      exp_q.push_back(LW'(m_level));
      check($sformatf("rnd%0d_q_level", i), int'(level), int'(exp_q.pop_front()));
      check_outputs($sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) begin
        logic [N-1:0] sp;
        if ($urandom_range(0, 3) != 0) sp = N'((1 << $urandom_range(0, N)) - 1);
        else                           sp = N'($urandom);
        press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sp);
        check_outputs($sformatf("rnd%0d_save", i));
      end
      if (i % 10 == 0) check_pwm($sformatf("rnd%0d_pwm", i), (m_level * 256 + N - 1) / N);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
